// File: rtl/tm_key_debouncer.sv
// Debounces and edge-detects the TM1638 raw key vector into clean level, press and release outputs.
// Latency: 2-cycle synchronizer plus debounce_ticks ticks; outputs change one cycle after the accepting tick edge.
// Backpressure: none; pulses are single-cycle and unbuffered, so consumers must sample every cycle.
// Optional auto-repeat of key_press while a key is held: define TM_KEY_AUTOREPEAT_EN.
module tm_key_debouncer #(
    parameter int clk_mhz             = 27,
    parameter int w_key               = 8,
    parameter int tick_div            = clk_mhz * 1000,
    parameter int debounce_ticks      = 10,
    parameter int repeat_delay_ticks  = 500,
    parameter int repeat_period_ticks = 100
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [w_key-1:0] keys,
    output logic [w_key-1:0] key_state,
    output logic [w_key-1:0] key_press,
    output logic [w_key-1:0] key_release,
    output logic             key_any
);

    localparam int TW = $clog2(tick_div + 1);
    localparam int CW = $clog2(debounce_ticks + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(tick_div - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(debounce_ticks - 1);

    // An out-of-range configuration never ticks, so every key simply stays released.
    localparam bit CFG_OK = (tick_div >= 1) && (debounce_ticks >= 1) && (debounce_ticks <= 255)
                         && (repeat_delay_ticks >= 1) && (repeat_period_ticks >= 1);

    logic [w_key-1:0] sync_q1;
    logic [w_key-1:0] sync;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [w_key-1:0] stable;
    logic [w_key-1:0] stable_nxt;
    logic [CW-1:0]    cnt     [w_key];
    logic [CW-1:0]    cnt_nxt [w_key];
    logic [w_key-1:0] press_acc;
    logic [w_key-1:0] release_acc;
    logic [w_key-1:0] rpt_pulse;

    // Two-flop synchronizer: the scan result changes asynchronously to key activity.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q1 <= '0;
            sync    <= '0;
        end else begin
            sync_q1 <= keys;
            sync    <= sync_q1;
        end
    end

    // Free-running prescaler, wraps at tick_div-1.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = CFG_OK && (tick_cnt == TICK_LAST);

    // Per-key debounce: count ticks of continuous mismatch, accept on the last one.
    always_comb begin
        stable_nxt  = stable;
        cnt_nxt     = cnt;
        press_acc   = '0;
        release_acc = '0;
        for (int i = 0; i < w_key; i++) begin
            if (sync[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i]  = sync[i];
                    cnt_nxt[i]     = '0;
                    press_acc[i]   = sync[i];
                    release_acc[i] = ~sync[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef TM_KEY_AUTOREPEAT_EN
    localparam int RMAX = (repeat_delay_ticks > repeat_period_ticks) ? repeat_delay_ticks
                                                                      : repeat_period_ticks;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DELAY  = RW'(repeat_delay_ticks);
    localparam logic [RW-1:0] RPT_PERIOD = RW'(repeat_period_ticks);

    logic [RW-1:0] rpt     [w_key];
    logic [RW-1:0] rpt_nxt [w_key];

    // Repeat countdown: armed by an accepted press, fires on the tick it expires.
    // The counter keeps running through a pending release, but a pulse is only
    // emitted when the synchronized level still agrees with the held state, so a
    // repeat can never land on or after a release.
    always_comb begin
        rpt_nxt   = rpt;
        rpt_pulse = '0;
        for (int i = 0; i < w_key; i++) begin
            if (press_acc[i]) begin
                rpt_nxt[i] = RPT_DELAY;
            end else if (!stable[i]) begin
                rpt_nxt[i] = '0;
            end else if (tick) begin
                if (rpt[i] <= RW'(1)) begin
                    rpt_nxt[i]   = RPT_PERIOD;
                    rpt_pulse[i] = (sync[i] == stable[i]);
                end else begin
                    rpt_nxt[i] = rpt[i] - RW'(1);
                end
            end
        end
    end

    // Repeat counter state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rpt <= '{default: '0};
        end else begin
            rpt <= rpt_nxt;
        end
    end
`else
    assign rpt_pulse = '0;
`endif

    // Debounce state and registered outputs; key_any tracks the next stable value
    // so it lines up with key_state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stable      <= '0;
            cnt         <= '{default: '0};
            key_press   <= '0;
            key_release <= '0;
            key_any     <= 1'b0;
        end else begin
            stable      <= stable_nxt;
            cnt         <= cnt_nxt;
            key_press   <= press_acc | rpt_pulse;
            key_release <= release_acc;
            key_any     <= |stable_nxt;
        end
    end

    assign key_state = stable;

endmodule

// File: tb/tb_tm_key_debouncer.sv
module tb_tm_key_debouncer;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] keys = 8'h00;
    logic [7:0] key_state;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic       key_any;

    tm_key_debouncer #(
        .clk_mhz            (27),
        .w_key              (8),
        .tick_div           (TD),
        .debounce_ticks     (DB),
        .repeat_delay_ticks (RD),
        .repeat_period_ticks(RP)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .keys       (keys),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_any    (key_any)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: the first rising edge with nrst high is edge 1.
    int edge_n;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    typedef struct {
        int         e;
        logic [7:0] press;
        logic [7:0] rel;
    } ev_t;

    typedef struct {
        int         e;
        logic [7:0] st;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Reference model: a key changes once its synchronized level has disagreed with
    // the accepted level over DB consecutive tick edges (ticks fall on edges that are
    // multiples of TD). Repeats fall on tick edges RD + k*RP ticks after the press.
    logic [7:0] m_stable;
    int         m_mis [8];
    int         m_acc [8];
    logic [7:0] raw_q[$];

    task automatic model_reset();
        m_stable = 8'h00;
        raw_q.delete();
        for (int i = 0; i < 8; i++) begin
            m_mis[i] = 0;
            m_acc[i] = 0;
        end
    endtask

    task automatic model_edge();
        int         e;
        int         nt;
        int         n;
        logic [7:0] s;
        logic [7:0] pr;
        logic [7:0] rl;
        e = edge_n + 1;
        raw_q.push_back(keys);
        s  = (raw_q.size() >= 3) ? raw_q[raw_q.size() - 3] : 8'h00;
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        pr = 8'h00;
        rl = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (s[i] == m_stable[i]) begin
                m_mis[i] = 0;
`ifdef TM_KEY_AUTOREPEAT_EN
                if (m_stable[i] && (e % TD == 0)) begin
                    n = (e - m_acc[i]) / TD;
                    if (n >= RD && ((n - RD) % RP) == 0) pr[i] = 1'b1;
                end
`endif
            end else begin
                if (m_mis[i] == 0) m_mis[i] = e;
                if (e % TD == 0) begin
                    nt = e / TD - (m_mis[i] - 1) / TD;
                    if (nt == DB) begin
                        m_stable[i] = s[i];
                        m_mis[i]    = 0;
                        if (s[i]) begin
                            pr[i]    = 1'b1;
                            m_acc[i] = e;
                        end else begin
                            rl[i] = 1'b1;
                        end
                    end
                end
            end
        end
        n = 0;
        st_q.push_back('{e: e, st: m_stable});
        if ((pr | rl) != 8'h00) ev_q.push_back('{e: e, press: pr, rel: rl});
    endtask

    task automatic cyc(input logic [7:0] k);
        @(negedge clk);
        nrst = 1'b1;
        keys = k;
        model_edge();
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        repeat (n) cyc(k);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: compares every output cycle against the expectations the driver queued.
    initial begin
        ev_t ev;
        st_t st;
        forever begin
            @(posedge clk);
            #1;
            if (!nrst) begin
                check("reset_outputs", {key_state, key_press, key_release, 7'b0, key_any}, 32'h0);
            end else if (st_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL no_expectation: got edge %0d want queued entry", edge_n);
            end else begin
                st = st_q.pop_front();
                check("state_edge", edge_n, st.e);
                check("key_state", {24'h0, key_state}, {24'h0, st.st});
                check("key_any", {31'h0, key_any}, {31'h0, |st.st});
                check("press_release_overlap", {24'h0, key_press & key_release}, 32'h0);
                while (ev_q.size() > 0 && ev_q[0].e < edge_n) begin
                    ev = ev_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed_pulse: got none want press %0h release %0h at edge %0d",
                             ev.press, ev.rel, ev.e);
                end
                if (ev_q.size() > 0 && ev_q[0].e == edge_n) begin
                    ev = ev_q.pop_front();
                    check("key_press", {24'h0, key_press}, {24'h0, ev.press});
                    check("key_release", {24'h0, key_release}, {24'h0, ev.rel});
                end else if ((key_press | key_release) != 8'h00) begin
                    check("unexpected_pulse", {16'h0, key_press, key_release}, 32'h0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [7:0] rk;
        int         run_left [8];

        model_reset();
        keys = 8'hFF;
        repeat (5) @(negedge clk);
        hold(8'hFF, 20);                 // all keys accepted together after release
        hold(8'h00, 20);

        hold(8'h04, 40);                 // clean press/release on key 2
        hold(8'h00, 20);

        hold(8'h01, 8);                  // glitch spanning two ticks
        hold(8'h00, 20);

        hold(8'h42, 20);                 // keys 1 and 6 together
        hold(8'h00, 20);

        hold(8'h08, 60);                 // long hold on key 3
        hold(8'h00, 20);

        hold(8'h20, 20);                 // reset while key 5 held
        do_reset(3);
        hold(8'h20, 20);
        hold(8'h00, 20);

        rk = 8'h00;
        for (int i = 0; i < 8; i++) run_left[i] = $urandom_range(1, 20);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (run_left[i] == 0) begin
                    rk[i] = ~rk[i];
                    run_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10)
                                                               : $urandom_range(12, 48);
                end
                run_left[i]--;
            end
            if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 4));
            cyc(rk);
        end
        hold(8'h00, 30);

        @(posedge clk);
        #2;
        check("leftover_events", ev_q.size(), 0);
        check("leftover_states", st_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
